// File: rtl/encoder_bank.sv
// Multi-channel quadrature decoder: synchronise, debounce, decode, count, and drive a bar display.
// Define ENCODER_BANK_ERR_EN to build the sticky illegal-transition flags; otherwise err is tied low.
//
// Quadrature phase state {a_db,b_db}:
//   state | meaning
//   Q00   | both phases low
//   Q01   | b high only (one step past Q00 in the up direction)
//   Q11   | both phases high, idle/reset position
//   Q10   | a high only (one step before Q00 in the up direction)
module encoder_bank #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 5,
  parameter int HIST_LEN  = 8,
  parameter int DIV_WIDTH = 10,
  parameter int WRAP      = 0,
  parameter int SEG_SHIFT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic [2:0]                sel,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       err,
  output logic [9:0]                segs,
  output logic                      tick
);

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  function automatic quad_t q_fwd(input quad_t q);
    case (q)
      Q00:     return Q01;
      Q01:     return Q11;
      Q11:     return Q10;
      default: return Q00;
    endcase
  endfunction

  function automatic quad_t q_rev(input quad_t q);
    case (q)
      Q00:     return Q10;
      Q10:     return Q11;
      Q11:     return Q01;
      default: return Q00;
    endcase
  endfunction

  logic [DIV_WIDTH-1:0] presc;
  logic                 strobe;
  logic [CHANNELS-1:0]  a_s1, a_s2, b_s1, b_s2;

  // Strobe is registered so it lands in the cycle the prescaler reads zero after a wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      strobe <= 1'b0;
    end else begin
      presc  <= presc + DIV_WIDTH'(1);
      strobe <= (presc == '1);
    end
  end

  assign tick = presc[DIV_WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1 <= '1;
      a_s2 <= '1;
      b_s1 <= '1;
      b_s2 <= '1;
    end else begin
      a_s1 <= a;
      a_s2 <= a_s1;
      b_s1 <= b;
      b_s2 <= b_s1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [HIST_LEN-1:0] a_hist, b_hist;
    logic                a_db, b_db;
    quad_t               cur_q, prev_q;
    logic [WIDTH-1:0]    cnt;
    logic                chg, up;
    logic                step_up, step_dn;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_hist <= '1;
        b_hist <= '1;
      end else if (strobe) begin
        a_hist <= {a_hist[HIST_LEN-2:0], a_s2[g]};
        b_hist <= {b_hist[HIST_LEN-2:0], b_s2[g]};
      end
    end

    // Hysteresis: a phase only moves once its whole history agrees.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_db <= 1'b1;
        b_db <= 1'b1;
      end else begin
        if (&a_hist)       a_db <= 1'b1;
        else if (~|a_hist) a_db <= 1'b0;
        if (&b_hist)       b_db <= 1'b1;
        else if (~|b_hist) b_db <= 1'b0;
      end
    end

    assign cur_q   = quad_t'({a_db, b_db});
    assign step_up = (cur_q == q_fwd(prev_q));
    assign step_dn = (cur_q == q_rev(prev_q));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prev_q <= Q11;
        cnt    <= '0;
        chg    <= 1'b0;
        up     <= 1'b0;
      end else begin
        prev_q <= cur_q;
        chg    <= step_up | step_dn;
        if (step_up) begin
          up <= 1'b1;
          if (cnt == CNT_MAX) cnt <= (WRAP != 0) ? '0 : CNT_MAX;
          else                cnt <= cnt + WIDTH'(1);
        end else if (step_dn) begin
          up <= 1'b0;
          if (cnt == '0) cnt <= (WRAP != 0) ? CNT_MAX : '0;
          else           cnt <= cnt - WIDTH'(1);
        end
      end
    end

    assign value[g*WIDTH +: WIDTH] = cnt;
    assign changed[g]              = chg;
    assign dir[g]                  = up;

`ifdef ENCODER_BANK_ERR_EN
    logic illegal, err_q;

    assign illegal = (cur_q != prev_q) && !step_up && !step_dn;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)        err_q <= 1'b0;
      else if (illegal) err_q <= 1'b1;
    end

    assign err[g] = err_q;
`else
    assign err[g] = 1'b0;
`endif
  end

  logic [WIDTH-1:0] disp_cnt;
  logic             disp_valid;
  logic [3:0]       seg_idx;
  logic [9:0]       seg_next;

  always_comb begin
    disp_cnt   = '0;
    disp_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == 3'(i)) begin
        disp_cnt   = value[i*WIDTH +: WIDTH];
        disp_valid = 1'b1;
      end
    end
  end

  // Bar position clamps at the last segment for large counts.
  always_comb begin
    seg_idx = 4'd0;
    if ((32'(disp_cnt) >> SEG_SHIFT) > 32'd9) seg_idx = 4'd9;
    else                                     seg_idx = 4'(32'(disp_cnt) >> SEG_SHIFT);
    seg_next = disp_valid ? (10'd1 << seg_idx) : 10'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) segs <= 10'b0000000001;
    else       segs <= seg_next;
  end

endmodule

// File: tb/tb_encoder_bank.sv
// Directed bench for encoder_bank: a saturating and a wrapping instance driven by the same phases.
// Expected err values follow ENCODER_BANK_ERR_EN when the bench is compiled with it.
module tb_encoder_bank;
  localparam int CH   = 2;
  localparam int W    = 5;
  localparam int HOLD = 32;

`ifdef ENCODER_BANK_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [CH-1:0]   a = '1, b = '1;
  logic [2:0]      sel = 3'd0;
  logic [CH*W-1:0] value0, value1;
  logic [CH-1:0]   chg0, chg1, dir0, dir1, err0, err1;
  logic [9:0]      segs0, segs1;
  logic            tick0, tick1;

  int vectors = 0;
  int miscompares = 0;
  int pc0[CH];
  int pc1[CH];
  logic [1:0] st0, st1;

  always #5 clk = ~clk;

  encoder_bank #(.CHANNELS(CH), .WIDTH(W), .HIST_LEN(4), .DIV_WIDTH(2), .WRAP(0), .SEG_SHIFT(1)) u_sat (
    .clk(clk), .reset(reset), .a(a), .b(b), .sel(sel), .value(value0), .changed(chg0),
    .dir(dir0), .err(err0), .segs(segs0), .tick(tick0));

  encoder_bank #(.CHANNELS(CH), .WIDTH(W), .HIST_LEN(4), .DIV_WIDTH(2), .WRAP(1), .SEG_SHIFT(1)) u_wrap (
    .clk(clk), .reset(reset), .a(a), .b(b), .sel(sel), .value(value1), .changed(chg1),
    .dir(dir1), .err(err1), .segs(segs1), .tick(tick1));

  initial begin
    for (int i = 0; i < CH; i++) begin
      pc0[i] = 0;
      pc1[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (chg0[i]) pc0[i]++;
      if (chg1[i]) pc1[i]++;
    end
  end

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [W-1:0] fld(input logic [CH*W-1:0] v, input int ch);
    return v[ch*W +: W];
  endfunction

  task automatic drive();
    a = {st1[1], st0[1]};
    b = {st1[0], st0[0]};
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    st0 = 2'b11;
    st1 = 2'b11;
    drive();
    reset = 1'b1;
    wait_clk(3);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({value0, value1} !== '0) begin
      miscompares++; $display("FAIL reset_value got %h/%h exp 0/0", value0, value1);
    end
    vectors++;
    if ({chg0, chg1, dir0, dir1, err0, err1} !== '0) begin
      miscompares++; $display("FAIL reset_flags got chg %b/%b dir %b/%b err %b/%b exp all 0", chg0, chg1, dir0, dir1, err0, err1);
    end
    vectors++;
    if (segs0 !== 10'b0000000001 || segs1 !== 10'b0000000001) begin
      miscompares++; $display("FAIL reset_segs got %b/%b exp 0000000001", segs0, segs1);
    end
    vectors++;
    if (tick0 !== 1'b0 || tick1 !== 1'b0) begin
      miscompares++; $display("FAIL reset_tick got %b/%b exp 0", tick0, tick1);
    end
    wait_clk(2);
    vectors++;
    if (tick0 !== 1'b1 || tick1 !== 1'b1) begin
      miscompares++; $display("FAIL tick_msb got %b/%b exp 1", tick0, tick1);
    end
  endtask

  task automatic test_clean_sequence();
    int p = pc0[0];
    for (int k = 1; k <= 4; k++) begin
      st0 = fwd(st0);
      drive();
      wait_clk(HOLD);
      vectors++;
      if (fld(value0, 0) !== W'(k) || fld(value1, 0) !== W'(k)) begin
        miscompares++; $display("FAIL clean_step%0d got %0d/%0d exp %0d", k, fld(value0, 0), fld(value1, 0), k);
      end
    end
    vectors++;
    if (pc0[0] - p !== 4) begin
      miscompares++; $display("FAIL clean_pulses got %0d exp 4", pc0[0] - p);
    end
    vectors++;
    if (dir0[0] !== 1'b1 || fld(value0, 1) !== '0) begin
      miscompares++; $display("FAIL clean_dir_ch1 got dir %b ch1 %0d exp dir 1 ch1 0", dir0[0], fld(value0, 1));
    end
  endtask

  task automatic test_glitch();
    int p = pc0[0];
    a = {st1[1], 1'b0};
    wait_clk(8);
    drive();
    wait_clk(HOLD);
    vectors++;
    if (fld(value0, 0) !== W'(4) || pc0[0] !== p) begin
      miscompares++; $display("FAIL glitch got value %0d pulses %0d exp value 4 pulses 0", fld(value0, 0), pc0[0] - p);
    end
  endtask

  task automatic test_saturate_high();
    int p0, p1;
    for (int k = 0; k < 27; k++) begin
      st0 = fwd(st0);
      drive();
      wait_clk(HOLD);
    end
    vectors++;
    if (fld(value0, 0) !== W'(31) || fld(value1, 0) !== W'(31)) begin
      miscompares++; $display("FAIL reach_31 got %0d/%0d exp 31/31", fld(value0, 0), fld(value1, 0));
    end
    p0 = pc0[0];
    p1 = pc1[0];
    st0 = fwd(st0);
    drive();
    wait_clk(HOLD);
    vectors++;
    if (fld(value0, 0) !== W'(31) || fld(value1, 0) !== W'(0)) begin
      miscompares++; $display("FAIL top_boundary got sat %0d wrap %0d exp 31/0", fld(value0, 0), fld(value1, 0));
    end
    vectors++;
    if (pc0[0] - p0 !== 1 || pc1[0] - p1 !== 1 || dir0[0] !== 1'b1) begin
      miscompares++; $display("FAIL top_pulse got pulses %0d/%0d dir %b exp 1/1 dir 1", pc0[0] - p0, pc1[0] - p1, dir0[0]);
    end
    st0 = rev(st0);
    drive();
    wait_clk(HOLD);
    vectors++;
    if (fld(value0, 0) !== W'(30) || fld(value1, 0) !== W'(31) || dir0[0] !== 1'b0) begin
      miscompares++; $display("FAIL step_down got %0d/%0d dir %b exp 30/31 dir 0", fld(value0, 0), fld(value1, 0), dir0[0]);
    end
  endtask

  task automatic test_saturate_low();
    int p;
    do_reset();
    p = pc0[1];
    st1 = rev(st1);
    drive();
    wait_clk(HOLD);
    vectors++;
    if (fld(value0, 1) !== W'(0) || fld(value1, 1) !== W'(31)) begin
      miscompares++; $display("FAIL bottom_boundary got sat %0d wrap %0d exp 0/31", fld(value0, 1), fld(value1, 1));
    end
    vectors++;
    if (pc0[1] - p !== 1 || fld(value0, 0) !== W'(0)) begin
      miscompares++; $display("FAIL bottom_pulse got pulses %0d ch0 %0d exp 1 and 0", pc0[1] - p, fld(value0, 0));
    end
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    sel = 3'd0;
    for (int k = 0; k < 5; k++) begin
      st0 = fwd(st0);
      st1 = fwd(st1);
      drive();
      wait_clk(HOLD);
    end
    vectors++;
    if (fld(value0, 0) !== W'(5) || fld(value0, 1) !== W'(5)) begin
      miscompares++; $display("FAIL both_up got %0d/%0d exp 5/5", fld(value0, 0), fld(value0, 1));
    end
    st0 = fwd(st0);
    st1 = rev(st1);
    drive();
    n = 0;
    while (fld(value0, 0) === W'(5) && n < 40) begin
      wait_clk(1);
      n++;
    end
    vectors++;
    if (n >= 40) begin
      miscompares++; $display("FAIL simul_timeout got value %0d exp 6 within 40 clk", fld(value0, 0));
    end
    vectors++;
    if (fld(value0, 0) !== W'(6) || fld(value0, 1) !== W'(4) || fld(value1, 0) !== W'(6) || fld(value1, 1) !== W'(4)) begin
      miscompares++; $display("FAIL simul_counts got %0d,%0d/%0d,%0d exp 6,4", fld(value0, 0), fld(value0, 1), fld(value1, 0), fld(value1, 1));
    end
    vectors++;
    if (segs0 !== 10'b0000000100) begin
      miscompares++; $display("FAIL segs_lag got %b exp 0000000100", segs0);
    end
    wait_clk(1);
    vectors++;
    if (segs0 !== 10'b0000001000 || segs1 !== 10'b0000001000) begin
      miscompares++; $display("FAIL segs_sel0 got %b/%b exp 0000001000", segs0, segs1);
    end
    sel = 3'd5;
    wait_clk(1);
    vectors++;
    if (segs0 !== 10'b0) begin
      miscompares++; $display("FAIL segs_sel5 got %b exp 0", segs0);
    end
    sel = 3'd1;
    wait_clk(1);
    vectors++;
    if (segs0 !== 10'b0000000100) begin
      miscompares++; $display("FAIL segs_sel1 got %b exp 0000000100", segs0);
    end
    sel = 3'd0;
  endtask

  task automatic test_illegal();
    int p = pc0[0];
    logic [CH-1:0] exp_err;
    exp_err = ERR_ON ? 2'b01 : 2'b00;
    st0 = st0 ^ 2'b11;
    drive();
    wait_clk(HOLD);
    vectors++;
    if (fld(value0, 0) !== W'(6) || pc0[0] !== p) begin
      miscompares++; $display("FAIL illegal_nocount got %0d pulses %0d exp 6 pulses 0", fld(value0, 0), pc0[0] - p);
    end
    vectors++;
    if (err0 !== exp_err || err1 !== exp_err) begin
      miscompares++; $display("FAIL illegal_err got %b/%b exp %b", err0, err1, exp_err);
    end
    st0 = fwd(st0);
    drive();
    wait_clk(HOLD);
    vectors++;
    if (fld(value0, 0) !== W'(7) || err0 !== exp_err) begin
      miscompares++; $display("FAIL err_sticky got value %0d err %b exp 7 err %b", fld(value0, 0), err0, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    int p;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      st0 = fwd(st0);
      drive();
      wait_clk(HOLD);
    end
    vectors++;
    if (fld(value0, 0) !== W'(7)) begin
      miscompares++; $display("FAIL mid_reach7 got %0d exp 7", fld(value0, 0));
    end
    st0 = rev(st0);
    drive();
    wait_clk(10);
    reset = 1'b1;
    #1;
    vectors++;
    if (fld(value0, 0) !== W'(0) || segs0 !== 10'b0000000001) begin
      miscompares++; $display("FAIL mid_async got value %0d segs %b exp 0 and 0000000001", fld(value0, 0), segs0);
    end
    wait_clk(2);
    @(negedge clk);
    p = pc0[0];
    st0 = 2'b10;
    drive();
    reset = 1'b0;
    wait_clk(14);
    vectors++;
    if (fld(value0, 0) !== W'(0) || fld(value1, 0) !== W'(0)) begin
      miscompares++; $display("FAIL mid_early got %0d/%0d exp 0/0", fld(value0, 0), fld(value1, 0));
    end
    wait_clk(20);
    vectors++;
    if (fld(value0, 0) !== W'(1) || pc0[0] - p !== 1) begin
      miscompares++; $display("FAIL mid_after got %0d pulses %0d exp 1 pulses 1", fld(value0, 0), pc0[0] - p);
    end
  endtask

  initial begin
    test_reset();
    test_clean_sequence();
    test_glitch();
    test_saturate_high();
    test_saturate_low();
    test_simultaneous();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion exp finish before 1ms");
    $fatal(1);
  end

endmodule
